// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable test patterns (bars, bands, white,
// checker, moving bar). Every output is registered one pxclk after the counters.
module video_pattern_gen #(
  parameter int unsigned HVID   = 1024,
  parameter int unsigned HFP    = 24,
  parameter int unsigned HS     = 136,
  parameter int unsigned HBP    = 160,
  parameter int unsigned VVID   = 768,
  parameter int unsigned VFP    = 3,
  parameter int unsigned VS     = 6,
  parameter int unsigned VBP    = 29,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned CBITS  = 1,
  parameter int unsigned BAR_W  = 128,
  parameter int unsigned CSH    = 5,
  parameter int unsigned MSH    = 6
) (
  input  logic             pxclk,
  input  logic             reset_n,
  input  logic [2:0]       mode_sel,
  output logic [CBITS-1:0] vga_red,
  output logic [CBITS-1:0] vga_grn,
  output logic [CBITS-1:0] vga_blu,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vid_active,
  output logic             frame_start
);

  localparam int unsigned HTOT = HVID + HFP + HS + HBP;
  localparam int unsigned VTOT = VVID + VFP + VS + VBP;
  localparam int unsigned HW   = $clog2(HTOT);
  localparam int unsigned VW   = $clog2(VTOT);
  localparam int unsigned PW   = $clog2(BAR_W + 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [PW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [2:0]    mode;
  logic [7:0]    frame_cnt;

  logic       h_last_c;
  logic       v_last_c;
  logic       active_c;
  logic       hs_c;
  logic       vs_c;
  logic       origin_c;
  logic [2:0] code_c;

  // Raster position decode
  always_comb begin
    h_last_c = (h == HW'(HTOT - 1));
    v_last_c = (v == VW'(VTOT - 1));
    active_c = (32'(h) < HVID) && (32'(v) < VVID);
    hs_c     = (32'(h) >= HVID + HFP) && (32'(h) < HVID + HFP + HS);
    vs_c     = (32'(v) >= VVID + VFP) && (32'(v) < VVID + VFP + VS);
    origin_c = (h == '0) && (v == '0);
  end

  // Pattern code {r,g,b} for the current pixel
  always_comb begin
    code_c = 3'b000;
    case (mode)
      3'd0: begin
        case (bar_idx)
          3'd0:    code_c = 3'b111;
          3'd1:    code_c = 3'b110;
          3'd2:    code_c = 3'b011;
          3'd3:    code_c = 3'b010;
          3'd4:    code_c = 3'b101;
          3'd5:    code_c = 3'b100;
          3'd6:    code_c = 3'b001;
          default: code_c = 3'b000;
        endcase
      end
      3'd1: begin
        if (32'(v) > 32'd300)      code_c = 3'(h >> 6);
        else if (32'(v) > 32'd290) code_c = 3'b000;
        else if (32'(v) > 32'd200) code_c = 3'(h >> 3);
        else if (32'(v) > 32'd190) code_c = 3'b000;
        else                       code_c = 3'(h);
      end
      3'd2: code_c = 3'b111;
      3'd3: code_c = {3{1'(h >> CSH) ^ 1'(v >> CSH)}};
      3'd4: code_c = {3{((8'(h >> MSH) ^ frame_cnt) & 8'h0F) == 8'h00}};
      default: code_c = 3'b000;
    endcase
  end

  // Counters, per-frame mode latch and frame counter
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      h         <= '0;
      v         <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      mode      <= '0;
      frame_cnt <= '0;
    end else if (h_last_c) begin
      h       <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
      if (v_last_c) begin
        v         <= '0;
        mode      <= mode_sel;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v <= v + VW'(1);
      end
    end else begin
      h <= h + HW'(1);
      // Bar index steps every BAR_W pixels and sticks at the last bar
      if (bar_px == PW'(BAR_W - 1)) begin
        bar_px <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + PW'(1);
      end
    end
  end

  // Output register stage
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      vga_red     <= '0;
      vga_grn     <= '0;
      vga_blu     <= '0;
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
      vid_active  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_red     <= {CBITS{active_c & code_c[2]}};
      vga_grn     <= {CBITS{active_c & code_c[1]}};
      vga_blu     <= {CBITS{active_c & code_c[0]}};
      vga_hsync   <= hs_c ? HS_POL : ~HS_POL;
      vga_vsync   <= vs_c ? VS_POL : ~VS_POL;
      vid_active  <= active_c;
      frame_start <= origin_c;
    end
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
Parameters:
REQ-001 SHALL have parameter HVID, default 1024, meaning active pixels per line.
REQ-002 SHALL have parameter HFP, default 24, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter HS, default 136, meaning hsync width in pixels.
REQ-004 SHALL have parameter HBP, default 160, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter VVID, default 768, meaning active lines per frame.
REQ-006 SHALL have parameter VFP, default 3, meaning vertical front porch in lines.
REQ-007 SHALL have parameter VS, default 6, meaning vsync width in lines.
REQ-008 SHALL have parameter VBP, default 29, meaning vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0, meaning hsync asserted level (0 = active-low).
REQ-010 SHALL have parameter VS_POL, default 0, meaning vsync asserted level (0 = active-low).
REQ-011 SHALL have parameter CBITS, default 1, meaning bits per colour channel (1..8).
REQ-012 SHALL have parameter BAR_W, default 128, meaning colour-bar width in pixels (>=1).
REQ-013 SHALL have parameter CSH, default 5, meaning checker square size of 2^CSH pixels.
REQ-014 SHALL have parameter MSH, default 6, meaning moving-bar width of 2^MSH pixels.

Ports:
REQ-015 SHALL have pxclk, input, 1, pixel clock (all logic on its rising edge).
REQ-016 SHALL have reset_n, input, 1, reset; asynchronous, active-low.
REQ-017 SHALL have mode_sel, input, 3, requested pattern mode.
REQ-018 SHALL have vga_red / vga_grn / vga_blu, output, CBITS each, pixel colour.
REQ-019 SHALL have vga_hsync / vga_vsync, output, 1 each, sync with parameterised polarity.
REQ-020 SHALL have vid_active, output, 1, high when the colour outputs show an active pixel.
REQ-021 SHALL have frame_start, output, 1, one-cycle pulse aligned with pixel (0,0) on the outputs.

Function
REQ-022 SHALL run h counter 0..HTOT-1 (HTOT=HVID+HFP+HS+HBP) and v counter 0..VTOT-1 (VTOT=VVID+VFP+VS+VBP); v advances only when h wraps; both wrap to 0; counter widths are $clog2 of the totals.
REQ-023 SHALL treat active as h<HVID && v<VVID.
REQ-024 SHALL assert hsync for HVID+HFP <= h < HVID+HFP+HS, and vsync for VVID+VFP <= v < VVID+VFP+VS, at the polarity given by HS_POL/VS_POL.
REQ-025 SHALL register all outputs, giving a latency of 1 pxclk from counter state to outputs, with colour, syncs, vid_active and frame_start mutually aligned.
REQ-026 SHALL force all colour bits to 0 whenever not active.
REQ-027 SHALL latch mode_sel into the active mode only at h==HTOT-1 && v==VTOT-1; mid-frame changes take effect from the next frame.
REQ-028 SHALL keep an 8-bit frame counter that increments at the same boundary as REQ-027 and wraps 255->0.
REQ-029 SHALL render colour through a 3-bit {r,g,b} code; each set bit drives its channel to all-ones (CBITS wide), and each clear bit drives it to 0.
REQ-030 SHALL implement mode 0 (colour bars) as follows: bar index from a pixel-in-bar counter cleared at h==0 and advanced every BAR_W pixels (no divider); index saturates at 7; codes for index 0..7 are 111,110,011,010,101,100,001,000.
REQ-031 SHALL implement mode 1 (banded) as follows: code = h[8:6] for v>300, 0 for 291..300, h[5:3] for 201..290, 0 for 191..200, h[2:0] for v<=190.
REQ-032 SHALL implement mode 2 as solid white (111).
REQ-033 SHALL implement mode 3 (checker) as code 111 if h[CSH]^v[CSH], else 000.
REQ-034 SHALL implement mode 4 (moving bar) as code 111 where h[MSH+3:MSH]==frame_cnt[3:0], else 000.
REQ-035 SHALL output black (000) for modes 5..7.

Reset
REQ-036 SHALL, while reset_n is low, hold h=v=0, frame_cnt=0, mode=0, colour=0, vid_active=0, frame_start=0, and syncs at deasserted level (~HS_POL, ~VS_POL).
REQ-037 SHALL, on the first rising pxclk after reset_n rises, present h=v=0 state on the outputs (vid_active=1, frame_start=1).
REQ-038 SHALL, on reset mid-frame, abort the frame immediately with no partial-line completion.

Verification
REQ-039 SHALL verify: default params, release reset -> frame_start period exactly 1344*806 cycles; hsync low 136 cycles starting 1048 cycles after line start; vsync low 6 lines starting at line 771.
REQ-040 SHALL verify: mode 0, line 0 -> colour code changes every 128 cycles in sequence 111,110,011,010,101,100,001,000; 000 during blanking.
REQ-041 SHALL verify: mode_sel changed 2->3 at line 400 -> white persists until frame end; checker begins at the next frame_start.
REQ-042 SHALL verify: CBITS=4, mode 2 -> each channel outputs 4'hF while active and 4'h0 during blanking.
REQ-043 SHALL verify: mode 4 over 3 frames -> white bar occupies h 0..63, then 64..127, then 128..191; frame 16 returns to 0..63.
REQ-044 SHALL verify: reset_n pulsed low at h=500,v=300 -> outputs go to reset values asynchronously, and counting restarts at (0,0) with frame_start=1.
